dual_lift: RTL and testbench

Two-car elevator controller for an 8-floor (0–7) shaft pair. Each car keeps its own request register and floor position and runs its own door/emergency logic. Car 1 and car 2 are identical and fully independent: there is no cross-car dispatching. The block sits between the hall/cab request decoders and the car drive and door actuators.

---
 rtl/dual_lift.sv | 124 ++++++++++++
 tb/tb_dual_lift.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_lift.sv
// Two independent elevator cars over an 8-floor shaft pair.
// Each car runs SCAN travel with one-cycle door dwell, an emergency freeze and full-car request refusal.

module dual_lift_car (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_floor,
    input  logic       emergency_stop,
    input  logic       full_capacity,
    output logic [1:0] door,
    output logic [2:0] current_floor,
    output logic [7:0] requests
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVING_UP,
        ST_MOVING_DOWN,
        ST_DOOR_OPEN,
        ST_EMERGENCY
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_floor, w_floor_nxt;
    logic [2:0] r_prev;
    logic [7:0] r_req, w_req_nxt;
    logic       r_dir, w_dir_nxt;   // 1 = up
    logic [7:0] w_set, w_clr;
    logic       w_has_above, w_has_below;

    assign w_has_above = |(r_req & (8'hFE << r_floor));
    assign w_has_below = |(r_req & ~(8'hFF << r_floor));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_floor <= 3'd0;
            r_prev  <= 3'd0;
            r_req   <= 8'd0;
            r_dir   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_floor <= w_floor_nxt;
            r_prev  <= req_floor;
            r_req   <= w_req_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_set       = 8'd0;
        w_clr       = 8'd0;
        w_state_nxt = ST_IDLE;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        // A level held on the input is captured once; a refused change is lost.
        if (req_floor != r_prev && !full_capacity)
            w_set[req_floor] = 1'b1;

        if (emergency_stop) begin
            w_state_nxt = ST_EMERGENCY;
        end else if (r_req[r_floor]) begin
            w_state_nxt      = ST_DOOR_OPEN;
            w_clr[r_floor]   = 1'b1;
        end else if (r_dir && w_has_above) begin
            w_state_nxt = ST_MOVING_UP;
            w_floor_nxt = r_floor + 3'd1;
        end else if (w_has_below) begin
            w_state_nxt = ST_MOVING_DOWN;
            w_dir_nxt   = 1'b0;
            w_floor_nxt = r_floor - 3'd1;
        end else if (w_has_above) begin
            w_state_nxt = ST_MOVING_UP;
            w_dir_nxt   = 1'b1;
            w_floor_nxt = r_floor + 3'd1;
        end

        // Set wins over clear on the same bit.
        w_req_nxt = (r_req & ~w_clr) | w_set;
    end

    assign door          = (r_state == ST_EMERGENCY) ? 2'b10 :
                           (r_state == ST_DOOR_OPEN) ? 2'b01 : 2'b00;
    assign current_floor = r_floor;
    assign requests      = r_req;
endmodule

module dual_lift (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_floor1,
    input  logic [2:0] req_floor2,
    input  logic       emergency_stop1,
    input  logic       emergency_stop2,
    input  logic       full_capacity1,
    input  logic       full_capacity2,
    output logic [1:0] door1,
    output logic [1:0] door2,
    output logic [2:0] current_floor1,
    output logic [2:0] current_floor2,
    output logic [7:0] requests1,
    output logic [7:0] requests2
);
    dual_lift_car u_car1 (
        .clk            (clk),
        .reset          (reset),
        .req_floor      (req_floor1),
        .emergency_stop (emergency_stop1),
        .full_capacity  (full_capacity1),
        .door           (door1),
        .current_floor  (current_floor1),
        .requests       (requests1)
    );

    dual_lift_car u_car2 (
        .clk            (clk),
        .reset          (reset),
        .req_floor      (req_floor2),
        .emergency_stop (emergency_stop2),
        .full_capacity  (full_capacity2),
        .door           (door2),
        .current_floor  (current_floor2),
        .requests       (requests2)
    );
endmodule

// File: tb/tb_dual_lift.sv
// Directed test-plan sequences plus randomized traffic, every cycle checked
// against a floor-list model of both cars.

module tb_dual_lift;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req_floor1, req_floor2;
    logic       emergency_stop1, emergency_stop2;
    logic       full_capacity1, full_capacity2;
    logic [1:0] door1, door2;
    logic [2:0] current_floor1, current_floor2;
    logic [7:0] requests1, requests2;

    int checks = 0;
    int failures = 0;

    dual_lift dut (
        .clk             (clk),
        .reset           (reset),
        .req_floor1      (req_floor1),
        .req_floor2      (req_floor2),
        .emergency_stop1 (emergency_stop1),
        .emergency_stop2 (emergency_stop2),
        .full_capacity1  (full_capacity1),
        .full_capacity2  (full_capacity2),
        .door1           (door1),
        .door2           (door2),
        .current_floor1  (current_floor1),
        .current_floor2  (current_floor2),
        .requests1       (requests1),
        .requests2       (requests2)
    );

    always #5 clk = ~clk;

    // Model: floor as an integer, pending floors as a bit list, direction as +1/-1.
    int m_floor[2];
    bit m_pend[2][8];
    int m_dir[2];
    int m_prev[2];
    int m_door[2];   // 0 closed, 1 open, 2 emergency-locked

    function automatic void model_edge(int c, bit rst, int rf, bit es, bit fc);
        int  newreq;
        int  served;
        bit  up_any, dn_any;
        if (rst) begin
            m_floor[c] = 0; m_dir[c] = 1; m_prev[c] = 0; m_door[c] = 0;
            for (int f = 0; f < 8; f++) m_pend[c][f] = 0;
            return;
        end
        newreq = (rf != m_prev[c] && !fc) ? rf : -1;
        served = -1;
        up_any = 0; dn_any = 0;
        for (int f = 0; f < 8; f++) begin
            if (m_pend[c][f] && f > m_floor[c]) up_any = 1;
            if (m_pend[c][f] && f < m_floor[c]) dn_any = 1;
        end
        m_door[c] = 0;
        if (es) m_door[c] = 2;
        else if (m_pend[c][m_floor[c]]) begin
            m_door[c] = 1;
            served = m_floor[c];
        end else if (m_dir[c] == 1 && up_any) m_floor[c] += 1;
        else if (dn_any) begin m_dir[c] = -1; m_floor[c] -= 1; end
        else if (up_any) begin m_dir[c] = 1; m_floor[c] += 1; end
        if (served >= 0) m_pend[c][served] = 0;
        if (newreq >= 0) m_pend[c][newreq] = 1;
        m_prev[c] = rf;
    endfunction

    function automatic logic [7:0] pend_bits(int c);
        logic [7:0] b;
        for (int f = 0; f < 8; f++) b[f] = m_pend[c][f];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_edge(0, reset, int'(req_floor1), emergency_stop1, full_capacity1);
        model_edge(1, reset, int'(req_floor2), emergency_stop2, full_capacity2);
        @(posedge clk);
        #1;
        chk("car1_floor", 8'(current_floor1), 8'(m_floor[0]));
        chk("car1_door",  8'(door1),          8'(m_door[0]));
        chk("car1_reqs",  requests1,          pend_bits(0));
        chk("car2_floor", 8'(current_floor2), 8'(m_floor[1]));
        chk("car2_door",  8'(door2),          8'(m_door[1]));
        chk("car2_reqs",  requests2,          pend_bits(1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_floor1 = 3'd0; req_floor2 = 3'd0;
        emergency_stop1 = 1'b0; emergency_stop2 = 1'b0;
        full_capacity1 = 1'b0; full_capacity2 = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    int q[$];

    initial begin
        // Reset overrides emergency and capture.
        reset = 1'b1;
        req_floor1 = 3'd5; req_floor2 = 3'd2;
        emergency_stop1 = 1'b1; emergency_stop2 = 1'b0;
        full_capacity1 = 1'b0; full_capacity2 = 1'b0;
        cyc();
        chk("rst_door1", 8'(door1), 8'h00);
        chk("rst_reqs1", requests1, 8'h00);
        chk("rst_floor2", 8'(current_floor2), 8'h00);
        do_reset();

        // 1: reset then request
        req_floor1 = 3'd3;
        cyc(); chk("t1_capture", requests1, 8'b0000_1000);
        cyc(); chk("t1_f1", 8'(current_floor1), 8'd1);
        cyc(); chk("t1_f2", 8'(current_floor1), 8'd2);
        cyc(); chk("t1_f3", 8'(current_floor1), 8'd3);
        cyc(); chk("t1_open", 8'(door1), 8'h01); chk("t1_clear", requests1, 8'h00);
        cyc(); chk("t1_close", 8'(door1), 8'h00);

        // 2: multiple pending requests on both cars
        do_reset();
        req_floor1 = 3'd3; req_floor2 = 3'd4; cyc();
        req_floor1 = 3'd6; req_floor2 = 3'd5; cyc();
        run(14);
        chk("t2_drain1", requests1, 8'h00);
        chk("t2_drain2", requests2, 8'h00);
        chk("t2_end1", 8'(current_floor1), 8'd6);
        chk("t2_end2", 8'(current_floor2), 8'd5);

        // 3: emergency pulse mid-travel
        do_reset();
        req_floor1 = 3'd5; cyc();
        run(2);
        emergency_stop1 = 1'b1; cyc();
        chk("t3_lock", 8'(door1), 8'h02);
        chk("t3_hold", 8'(current_floor1), 8'd2);
        chk("t3_kept", requests1, 8'b0010_0000);
        emergency_stop1 = 1'b0;
        run(8);
        chk("t3_arrive", 8'(current_floor1), 8'd5);
        chk("t3_drain", requests1, 8'h00);

        // 4: full capacity refusal on car 2
        do_reset();
        req_floor2 = 3'd4; cyc();
        full_capacity2 = 1'b1; req_floor2 = 3'd7; cyc();
        chk("t4_refused", requests2, 8'b0001_0000);
        run(6);
        chk("t4_served", 8'(current_floor2), 8'd4);
        chk("t4_none", requests2, 8'h00);
        full_capacity2 = 1'b0;
        req_floor2 = 3'd6; cyc();
        req_floor2 = 3'd7; cyc();
        run(8);
        chk("t4_top", 8'(current_floor2), 8'd7);

        // 5: reversal at floor 6 moving up with {7,3} pending
        do_reset();
        req_floor1 = 3'd7; cyc();
        run(4);
        req_floor1 = 3'd3; cyc();
        cyc();
        chk("t5_at6", 8'(current_floor1), 8'd6);
        q.delete();
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (door1 == 2'b01) q.push_back(int'(current_floor1));
        end
        chk("t5_nstops", 8'(q.size()), 8'd2);
        if (q.size() == 2) begin
            chk("t5_first", 8'(q[0]), 8'd7);
            chk("t5_second", 8'(q[1]), 8'd3);
        end

        // 6: held input does not re-request
        run(5);
        chk("t6_reqs", requests1, 8'h00);
        chk("t6_door", 8'(door1), 8'h00);
        chk("t6_floor", 8'(current_floor1), 8'd3);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) req_floor1 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 3) req_floor2 = 3'($urandom_range(0, 7));
            emergency_stop1 = ($urandom_range(0, 19) == 0);
            emergency_stop2 = ($urandom_range(0, 19) == 0);
            full_capacity1  = ($urandom_range(0, 6) == 0);
            full_capacity2  = ($urandom_range(0, 6) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
